// File: rtl/pc_sequencer.sv
// pc_sequencer -- control FSM that sequences instruction fetch, execute and
// program-counter commit. It is the only writer of the program counter.
//
// Optional feature macro: PC_SEQUENCER_CALL_STACK_EN
//   Defined  : STACK_DEPTH-entry return stack driven by call/ret.
//   Undefined: no stack storage; call and ret are accepted but ignored.
//
// Ports:
//   clock, reset_n       rising-edge clock, synchronous active-low reset
//   run, halt_req        start/resume level, stop-after-instruction request
//   pc_current           current program counter value
//   fetch_req/addr/ack   instruction memory handshake
//   exec_start/done      core execute handshake (start is a 1-cycle pulse)
//   branch_*             redirect info, valid with exec_done
//   call, ret            return-stack controls, valid with exec_done
//   pc_*_enable, pc_value  strobes and operand for the program counter
//   halted, fault        status (fault is sticky until reset)
module pc_sequencer #(
  parameter int WORD_SIZE     = 16,
  parameter int RESET_VECTOR  = 0,
  parameter int INSTR_STRIDE  = 1,
  parameter int FETCH_TIMEOUT = 16,
  parameter int STACK_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic [WORD_SIZE-1:0] pc_current,
  output logic                 fetch_req,
  output logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 fetch_ack,
  output logic                 exec_start,
  input  logic                 exec_done,
  input  logic                 branch_taken,
  input  logic                 branch_relative,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 call,
  input  logic                 ret,
  output logic                 pc_reset_enable,
  output logic                 pc_update_enable,
  output logic                 pc_set_enable,
  output logic [WORD_SIZE-1:0] pc_value,
  output logic                 halted,
  output logic                 fault
);

  localparam logic [WORD_SIZE-1:0] RESET_PC = WORD_SIZE'(RESET_VECTOR);
  localparam logic [WORD_SIZE-1:0] STRIDE   = WORD_SIZE'(INSTR_STRIDE);
  localparam int                   TMO_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_EXEC, S_UPDATE, S_HALTED
  } state_t;

  state_t                 state_reg;
  logic                   halt_pending_reg;
  logic                   fault_reg;
  logic [TMO_W-1:0]       tmo_reg;
  logic                   exec_first_reg;
  logic                   taken_reg;
  logic                   relative_reg;
  logic [WORD_SIZE-1:0]   target_reg;

  // Stack decisions, driven by the feature build or tied off below.
  logic                   do_ret;
  logic                   do_push;
  logic                   stack_err;
  logic [WORD_SIZE-1:0]   stack_top;

`ifdef PC_SEQUENCER_CALL_STACK_EN
  localparam int               SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

  logic [SP_W-1:0]      sp_reg;
  logic                 call_reg;
  logic                 ret_reg;
  logic [WORD_SIZE-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]      top_idx;

  assign top_idx   = sp_reg - SP_W'(1);
  assign stack_top = (sp_reg == '0) ? '0 : stack_mem[top_idx];
  // ret takes priority; a call only pushes when its branch is actually taken.
  assign do_ret    = ret_reg;
  assign do_push   = call_reg && taken_reg && !ret_reg;
  assign stack_err = (do_ret && sp_reg == '0) || (do_push && sp_reg == SP_FULL);

  // Return address is the instruction after the call, taken before the
  // PC moves at the end of UPDATE.
  always_ff @(posedge clock) begin
    if (state_reg == S_UPDATE && do_push && !stack_err)
      stack_mem[sp_reg] <= pc_current + STRIDE;
  end
`else
  assign do_ret    = 1'b0;
  assign do_push   = 1'b0;
  assign stack_err = 1'b0;
  assign stack_top = '0;
  wire unused_stack_inputs = &{1'b0, call, ret, do_push, 32'(STACK_DEPTH)};
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      halt_pending_reg <= 1'b0;
      fault_reg        <= 1'b0;
      tmo_reg          <= '0;
      exec_first_reg   <= 1'b0;
      taken_reg        <= 1'b0;
      relative_reg     <= 1'b0;
      target_reg       <= '0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
      sp_reg           <= '0;
      call_reg         <= 1'b0;
      ret_reg          <= 1'b0;
`endif
    end else begin
      exec_first_reg <= 1'b0;
      // Latch here; any HALTED entry below overrides this with a clear.
      if (state_reg != S_IDLE && halt_req)
        halt_pending_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (run)
            state_reg <= S_START;
        end
        S_START: begin
          tmo_reg   <= '0;
          state_reg <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch_ack) begin
            exec_first_reg <= 1'b1;
            state_reg      <= S_EXEC;
          end else if (tmo_reg == TMO_LAST) begin
            fault_reg        <= 1'b1;
            halt_pending_reg <= 1'b0;
            state_reg        <= S_HALTED;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            taken_reg    <= branch_taken;
            relative_reg <= branch_relative;
            target_reg   <= branch_target;
`ifdef PC_SEQUENCER_CALL_STACK_EN
            call_reg     <= call;
            ret_reg      <= ret;
`endif
            state_reg    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (stack_err) begin
            fault_reg        <= 1'b1;
            halt_pending_reg <= 1'b0;
            state_reg        <= S_HALTED;
          end else begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
            if (do_ret)
              sp_reg <= sp_reg - SP_W'(1);
            else if (do_push)
              sp_reg <= sp_reg + SP_W'(1);
`endif
            // halt_req seen in this very cycle is honoured too.
            if (halt_pending_reg || halt_req || !run) begin
              halt_pending_reg <= 1'b0;
              state_reg        <= S_HALTED;
            end else begin
              tmo_reg   <= '0;
              state_reg <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          if (run && !halt_req && !fault_reg) begin
            tmo_reg   <= '0;
            state_reg <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from state and captured branch info.
  logic update_ok;
  logic abs_jump;

  assign update_ok  = (state_reg == S_UPDATE) && !stack_err;
  assign abs_jump   = taken_reg && !relative_reg;

  assign fetch_req  = (state_reg == S_FETCH);
  assign fetch_addr = (state_reg == S_FETCH) ? pc_current : '0;
  assign exec_start = (state_reg == S_EXEC) && exec_first_reg;
  assign halted     = (state_reg == S_HALTED);
  assign fault      = fault_reg;

  // START loads RESET_VECTOR through the set strobe, so the PC's own reset
  // input is never needed.
  assign pc_reset_enable  = 1'b0;
  assign pc_set_enable    = (state_reg == S_START) || (update_ok && (do_ret || abs_jump));
  assign pc_update_enable = update_ok && !do_ret && !abs_jump;

  always_comb begin
    pc_value = '0;
    if (state_reg == S_START)
      pc_value = RESET_PC;
    else if (update_ok) begin
      if (do_ret)
        pc_value = stack_top;
      else if (taken_reg)
        pc_value = target_reg;
      else
        pc_value = STRIDE;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: plays the program counter, instruction memory
// and core, and checks every fetch address and PC strobe against a model
// that applies the step / relative / absolute / stack rules directly.
module tb_pc_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset_n, run, halt_req, fetch_ack, exec_done;
  logic         branch_taken, branch_relative, call, ret;
  logic [W-1:0] branch_target;
  logic [W-1:0] pc_current = 16'hBEEF;
  logic         fetch_req, exec_start, pc_reset_enable, pc_update_enable;
  logic         pc_set_enable, halted, fault;
  logic [W-1:0] fetch_addr, pc_value;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] model_pc;
`ifdef PC_SEQUENCER_CALL_STACK_EN
  logic [W-1:0] mstack [$];
`endif

  always #5 clock = ~clock;

  pc_sequencer #(
    .WORD_SIZE(W), .RESET_VECTOR(0), .INSTR_STRIDE(1),
    .FETCH_TIMEOUT(16), .STACK_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .halt_req(halt_req),
    .pc_current(pc_current), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .exec_start(exec_start), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_relative(branch_relative),
    .branch_target(branch_target), .call(call), .ret(ret),
    .pc_reset_enable(pc_reset_enable), .pc_update_enable(pc_update_enable),
    .pc_set_enable(pc_set_enable), .pc_value(pc_value),
    .halted(halted), .fault(fault)
  );

  // Program counter stand-in, obeying the strobes.
  always @(posedge clock) begin
    if (pc_reset_enable)       pc_current <= '0;
    else if (pc_set_enable)    pc_current <= pc_value;
    else if (pc_update_enable) pc_current <= pc_current + pc_value;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference rule for a non-stack commit.
  function automatic void branch_rule(input logic tk, input logic rel,
                                      input logic [W-1:0] tgt, input logic [W-1:0] pc,
                                      output logic set, output logic upd,
                                      output logic [W-1:0] val, output logic [W-1:0] nxt);
    if (tk && !rel) begin
      set = 1'b1; upd = 1'b0; val = tgt; nxt = tgt;
    end else begin
      set = 1'b0; upd = 1'b1;
      val = tk ? tgt : W'(1);
      nxt = pc + val;
    end
  endfunction

  // One instruction from FETCH through UPDATE; returns one cycle after UPDATE.
  task automatic do_instr(input logic tk, input logic rel, input logic [W-1:0] tgt,
                          input int ack_dly, input int done_dly, input logic hreq,
                          input logic c, input logic r);
    logic         exp_set, exp_upd, exp_err;
    logic [W-1:0] exp_val, next_pc;
    n_cmp++;
    if (fetch_req !== 1'b1 || fetch_addr !== model_pc) begin
      n_bad++;
      $display("FAIL fetch: got req=%b addr=%h, expected req=1 addr=%h", fetch_req, fetch_addr, model_pc);
    end
    fetch_ack = 1'b0;
    repeat (ack_dly) tick();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    n_cmp++;
    if (exec_start !== 1'b1) begin
      n_bad++;
      $display("FAIL exec_start_first: got %b expected 1", exec_start);
    end
    halt_req = hreq;
    for (int i = 0; i < done_dly; i++) begin
      tick();
      halt_req = 1'b0;
      n_cmp++;
      if (exec_start !== 1'b0 || pc_set_enable !== 1'b0 || pc_update_enable !== 1'b0) begin
        n_bad++;
        $display("FAIL exec_wait: got start=%b set=%b upd=%b expected 0 0 0",
                 exec_start, pc_set_enable, pc_update_enable);
      end
    end
    exec_done = 1'b1; branch_taken = tk; branch_relative = rel;
    branch_target = tgt; call = c; ret = r;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0; branch_relative = 1'b0;
    branch_target = '0; call = 1'b0; ret = 1'b0; halt_req = 1'b0;

    exp_err = 1'b0; exp_set = 1'b0; exp_upd = 1'b0; exp_val = '0; next_pc = model_pc;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    if (r) begin
      if (mstack.size() == 0) exp_err = 1'b1;
      else begin
        exp_set = 1'b1; exp_val = mstack.pop_back(); next_pc = exp_val;
      end
    end else if (c && tk && mstack.size() >= DEPTH) begin
      exp_err = 1'b1;
    end else begin
      if (c && tk) mstack.push_back(model_pc + W'(1));
      branch_rule(tk, rel, tgt, model_pc, exp_set, exp_upd, exp_val, next_pc);
    end
`else
    branch_rule(tk, rel, tgt, model_pc, exp_set, exp_upd, exp_val, next_pc);
`endif
    n_cmp++;
    if ({pc_set_enable, pc_update_enable, pc_reset_enable} !== {exp_set, exp_upd, 1'b0} ||
        pc_value !== exp_val) begin
      n_bad++;
      $display("FAIL update_strobe: got set=%b upd=%b rst=%b val=%h expected set=%b upd=%b rst=0 val=%h",
               pc_set_enable, pc_update_enable, pc_reset_enable, pc_value, exp_set, exp_upd, exp_val);
    end
    model_pc = next_pc;
    tick();
    n_cmp++;
    if (hreq || exp_err) begin
      if (halted !== 1'b1 || fault !== exp_err || fetch_req !== 1'b0) begin
        n_bad++;
        $display("FAIL post_update_halt: got halted=%b fault=%b req=%b expected 1 %b 0",
                 halted, fault, fetch_req, exp_err);
      end
    end else if (fetch_req !== 1'b1 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL post_update_fetch: got req=%b halted=%b expected 1 0", fetch_req, halted);
    end
    $display("instr tk=%b rel=%b tgt=%h call=%b ret=%b hreq=%b -> next pc %h",
             tk, rel, tgt, c, r, hreq, model_pc);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({fetch_req, exec_start, pc_reset_enable, pc_update_enable, pc_set_enable,
         halted, fault, fetch_addr, pc_value} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b st=%b rst=%b upd=%b set=%b h=%b f=%b addr=%h val=%h expected all 0",
               fetch_req, exec_start, pc_reset_enable, pc_update_enable, pc_set_enable,
               halted, fault, fetch_addr, pc_value);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({fetch_req, pc_set_enable, pc_update_enable, halted} !== 4'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got req=%b set=%b upd=%b halted=%b expected 0", fetch_req,
               pc_set_enable, pc_update_enable, halted);
    end
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    n_cmp++;
    if (pc_set_enable !== 1'b1 || pc_update_enable !== 1'b0 || pc_value !== 16'h0000) begin
      n_bad++;
      $display("FAIL start_strobe: got set=%b upd=%b val=%h expected 1 0 0000",
               pc_set_enable, pc_update_enable, pc_value);
    end
    tick();
    model_pc = 16'h0000;
  endtask

  task automatic test_sequential();
    start_run();
    for (int i = 0; i < 4; i++) do_instr(1'b0, 1'b0, '0, 1, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_relative();
    do_instr(1'b1, 1'b0, 16'h0005, 1, 1, 1'b0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b1, 16'hFFFE, 1, 2, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (fetch_addr !== 16'h0003) begin
      n_bad++;
      $display("FAIL rel_branch_addr: got %h expected 0003", fetch_addr);
    end
  endtask

  task automatic test_random();
    logic hreq;
    for (int i = 0; i < 40; i++) begin
      hreq = ($urandom_range(0, 7) == 0);
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), hreq, 1'b0, 1'b0);
      if (hreq) tick();
    end
  endtask

  task automatic test_abs_halt();
    do_instr(1'b1, 1'b0, 16'h0002, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b0, 16'h0040, 1, 2, 1'b1, 1'b0, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (halted !== 1'b1 || pc_set_enable !== 1'b0 || pc_update_enable !== 1'b0) begin
        n_bad++;
        $display("FAIL halted_hold: got halted=%b set=%b upd=%b expected 1 0 0",
                 halted, pc_set_enable, pc_update_enable);
      end
    end
    run = 1'b1;
    tick();
    n_cmp++;
    if (fetch_req !== 1'b1 || fetch_addr !== 16'h0040 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_addr: got req=%b addr=%h halted=%b expected 1 0040 0",
               fetch_req, fetch_addr, halted);
    end
  endtask

  task automatic test_timeout();
    fetch_ack = 1'b0;
    repeat (15) tick();
    n_cmp++;
    if (fetch_req !== 1'b1 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: got req=%b fault=%b expected 1 0", fetch_req, fault);
    end
    tick();
    n_cmp++;
    if (halted !== 1'b1 || fault !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_fault: got halted=%b fault=%b expected 1 1", halted, fault);
    end
    repeat (4) tick();
    n_cmp++;
    if (halted !== 1'b1 || fault !== 1'b1 || fetch_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_blocks_resume: got halted=%b fault=%b req=%b expected 1 1 0",
               halted, fault, fetch_req);
    end
    reset_n = 1'b0; run = 1'b0;
    tick();
    n_cmp++;
    if ({fetch_req, halted, fault, pc_set_enable, pc_update_enable} !== 5'b0) begin
      n_bad++;
      $display("FAIL fault_reset: got req=%b halted=%b fault=%b set=%b upd=%b expected 0",
               fetch_req, halted, fault, pc_set_enable, pc_update_enable);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_exec();
    start_run();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    n_cmp++;
    if (exec_start !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_exec_enter: got exec_start=%b expected 1", exec_start);
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({fetch_req, exec_start, pc_reset_enable, pc_update_enable, pc_set_enable,
         halted, fault, fetch_addr, pc_value} !== '0 || pc_current !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_exec_reset: got req=%b st=%b upd=%b set=%b val=%h pc=%h expected all 0",
               fetch_req, exec_start, pc_update_enable, pc_set_enable, pc_value, pc_current);
    end
    reset_n = 1'b1; run = 1'b0;
    tick();
  endtask

`ifdef PC_SEQUENCER_CALL_STACK_EN
  task automatic test_call_stack();
    mstack.delete();
    start_run();
    do_instr(1'b1, 1'b0, 16'h0010, 0, 1, 1'b0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b0, 16'h0080, 1, 1, 1'b0, 1'b1, 1'b0);
    do_instr(1'b0, 1'b0, 16'h0000, 1, 1, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (fetch_addr !== 16'h0011) begin
      n_bad++;
      $display("FAIL ret_addr: got %h expected 0011", fetch_addr);
    end
    for (int i = 0; i < 5; i++)
      do_instr(1'b1, 1'b0, W'(16'h0100 + i), 0, 1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (pc_current !== model_pc || fault !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_pc: got pc=%h fault=%b expected pc=%h fault=1",
               pc_current, fault, model_pc);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; run = 1'b0; halt_req = 1'b0; fetch_ack = 1'b0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_relative = 1'b0;
    branch_target = '0; call = 1'b0; ret = 1'b0; model_pc = '0;
    tick();
    tick();
    test_reset();
    test_sequential();
    test_relative();
    test_random();
    test_abs_halt();
    test_timeout();
    test_reset_mid_exec();
`ifdef PC_SEQUENCER_CALL_STACK_EN
    test_call_stack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that drives the program counter's reset/update/set strobes and value bus.
- Sequences the fetch handshake with instruction memory and the execute handshake with the core.
- Commits the next PC after every instruction: sequential step, relative branch or absolute jump.
- Sits between the core control path and the program counter, which is its sole writer.

Parameters:
- WORD_SIZE, 16, width of PC/address/branch buses.
- RESET_VECTOR, 0, PC value loaded on start.
- INSTR_STRIDE, 1, sequential PC increment.
- FETCH_TIMEOUT, 16, max cycles in FETCH without ack before fault.
- STACK_DEPTH, 4, return-stack entries (feature only).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  level; start from IDLE / resume from HALTED.
- halt_req  in  1  request stop after current instruction.
- pc_current  in  WORD_SIZE  program counter output.
- fetch_req  out  1  instruction read request.
- fetch_addr  out  WORD_SIZE  read address.
- fetch_ack  in  1  instruction delivered.
- exec_start  out  1  one-cycle pulse, instruction ready for core.
- exec_done  in  1  core finished; branch fields valid this cycle.
- branch_taken  in  1  redirect PC.
- branch_relative  in  1  1: target is signed offset; 0: absolute.
- branch_target  in  WORD_SIZE  offset or absolute target.
- call  in  1  push return address (feature only).
- ret  in  1  pop return address (feature only).
- pc_reset_enable  out  1  strobe to PC.
- pc_update_enable  out  1  strobe to PC: PC += pc_value.
- pc_set_enable  out  1  strobe to PC: PC = pc_value.
- pc_value  out  WORD_SIZE  operand for the PC.
- halted  out  1  in HALTED.
- fault  out  1  sticky error.

Behaviour:
- States: IDLE, START, FETCH, EXEC, UPDATE, HALTED.
- Reset: reset_n low at a rising edge forces IDLE from any state, including mid-fetch or mid-exec.
  - Clears halt_pending, fault, timeout counter, captured branch info and stack pointer.
  - All outputs 0 while in IDLE.
- Outputs are Moore, decoded from state and registered captures.
- At most one pc_* enable is high in any cycle.
- IDLE: run=1 -> START.
- START (1 cycle): pc_set_enable=1, pc_value=RESET_VECTOR -> FETCH. PC is valid on FETCH entry.
- FETCH:
  - fetch_req=1, fetch_addr=pc_current.
  - fetch_ack=1 -> EXEC, exec_start=1 for exactly the first EXEC cycle.
  - Timeout counter increments each FETCH cycle without ack. Reaching FETCH_TIMEOUT -> fault=1, go to HALTED.
  - Counter clears on FETCH entry.
- EXEC: wait for exec_done. On exec_done, register branch_taken, branch_relative, branch_target, call, ret -> UPDATE.
- UPDATE (1 cycle):
  - Not taken: pc_update_enable=1, pc_value=INSTR_STRIDE.
  - Taken, relative: pc_update_enable=1, pc_value=branch_target. Two's-complement add, mod 2^WORD_SIZE.
  - Taken, absolute: pc_set_enable=1, pc_value=branch_target.
  - Next state: HALTED if halt_pending or run=0, else FETCH.
- halt_req: latched into halt_pending in any non-IDLE state; honoured only at UPDATE exit, so no instruction is abandoned. Cleared on HALTED entry.
- HALTED:
  - halted=1, no strobes.
  - run=1, halt_req=0, fault=0 -> FETCH (resume at current PC, no reload).
  - fault=1 blocks resume; only reset clears it.
- Wrap-around: PC arithmetic wraps at WORD_SIZE; no fault on wrap.

Optional Feature:
- Macro: PC_SEQUENCER_CALL_STACK_EN.
- Enabled: STACK_DEPTH-entry LIFO, updated in UPDATE.
  - call with taken: push pc_current+INSTR_STRIDE, then apply the branch.
  - ret: pc_set_enable with popped value; branch fields ignored.
  - call and ret together: ret wins, no push.
  - Push when full, or pop when empty: fault=1, no PC strobe, -> HALTED.
- Disabled: no stack storage; call and ret ignored; ports remain present.

Test Plan:
- Start, sequential run: reset_n=0 for 2 cycles, then run=1, RESET_VECTOR=0; ack every fetch after 1 cycle, exec_done after 2 cycles, not taken -> one pc_set_enable(0) in START, then fetch_addr 0,1,2,3, pc_update_enable(1) per instruction.
- Relative branch: at PC=5, exec_done with taken=1, relative=1, target=0xFFFE -> pc_update_enable with value 0xFFFE; next fetch_addr=3.
- Absolute jump and halt: halt_req pulsed during EXEC at PC=2, taken absolute target=0x40 -> pc_set_enable(0x40), then HALTED with halted=1. run=1 -> next fetch_addr=0x40.
- Fetch timeout: withhold fetch_ack for 16 cycles -> fault=1, HALTED. run=1 stays halted; reset_n=0 clears fault and returns to IDLE.
- Reset mid-exec: reset_n=0 while in EXEC -> next cycle all outputs 0, IDLE; no PC strobe emitted.
- Feature on, STACK_DEPTH=4: call at PC=0x10 to 0x80, then ret -> PC=0x11. 5 nested calls -> fault on the 5th, PC unchanged.
